imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_pkg.sv | 25 ++
 rtl/imem_byte_ram.sv | 33 +++
 rtl/imem_loader.sv | 164 ++++++++++++++++
 tb/tb_imem_loader.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, memory geometry
// and load limits.
package imem_pkg;

    localparam logic [31:0] BASE_ADDR = 32'h0000_3000;
    localparam int          MEM_BYTES = 1024;
    localparam int          ADDR_W    = 10;
    localparam int          MAX_WORDS = 256;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_HI  = 3'd1,
        ST_HDR_LO  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHK     = 3'd4,
        ST_DONE    = 3'd5,
        ST_ERR     = 3'd6
    } state_e;

    // States in which the loader owns the byte stream.
    function automatic logic is_load_state(input state_e s);
        return (s == ST_HDR_HI) || (s == ST_HDR_LO) || (s == ST_PAYLOAD) || (s == ST_CHK);
    endfunction

endpackage

// File: rtl/imem_byte_ram.sv
// 1024x8 instruction memory: one synchronous byte write port, one combinational
// big-endian 32-bit read port whose byte addresses wrap within the array.
module imem_byte_ram
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [7:0]        wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    // No reset: contents survive a reset so a partially loaded image stays readable.
    logic [7:0] mem [MEM_BYTES];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    logic [ADDR_W-1:0] raddr_1;
    logic [ADDR_W-1:0] raddr_2;
    logic [ADDR_W-1:0] raddr_3;

    assign raddr_1 = raddr + 10'd1;
    assign raddr_2 = raddr + 10'd2;
    assign raddr_3 = raddr + 10'd3;

    assign rdata = {mem[raddr], mem[raddr_1], mem[raddr_2], mem[raddr_3]};

endmodule

// File: rtl/imem_loader.sv
// Streams a length-prefixed program image into the instruction memory and serves
// fetch reads. Optional trailing XOR checksum enabled by IMEM_LOAD_CHECKSUM_EN.
module imem_loader
    import imem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    input  logic [31:0] rd_addr,
    output logic [31:0] rd_data,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [8:0]  words_loaded,
    output state_e      dbg_state
);

    localparam logic [15:0] MAX_N = 16'(MAX_WORDS);

`ifdef IMEM_LOAD_CHECKSUM_EN
    localparam state_e ST_FINISH = ST_CHK;
`else
    localparam state_e ST_FINISH = ST_DONE;
`endif

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        n_hi_q, n_hi_d;
    logic [15:0]       n_q, n_d;
    logic [8:0]        wl_q, wl_d;
    logic              we;
    logic              accept;
    logic [15:0]       hdr_n;
    logic [8:0]        wl_inc;

`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    // Handshake: a byte moves on a rising edge where byte_valid && byte_ready;
    // byte_ready depends only on state, byte_valid may drop at any time to stall.
    assign byte_ready = is_load_state(state_q);
    assign accept     = byte_valid && byte_ready;
    assign hdr_n      = {n_hi_q, byte_in};
    assign wl_inc     = wl_q + 9'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            n_hi_q  <= '0;
            n_q     <= '0;
            wl_q    <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            n_hi_q  <= n_hi_d;
            n_q     <= n_d;
            wl_q    <= wl_d;
        end
    end

`ifdef IMEM_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        n_hi_d  = n_hi_q;
        n_d     = n_q;
        wl_d    = wl_q;
        we      = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_HDR_HI;
                    ptr_d   = '0;
                    n_hi_d  = '0;
                    n_d     = '0;
                    wl_d    = '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            ST_HDR_HI: begin
                if (accept) begin
                    n_hi_d  = byte_in;
                    state_d = ST_HDR_LO;
                end
            end
            ST_HDR_LO: begin
                if (accept) begin
                    n_d = hdr_n;
                    if (hdr_n == 16'd0) begin
                        state_d = ST_FINISH;
                    end else if (hdr_n > MAX_N) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_PAYLOAD;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    we    = 1'b1;
                    ptr_d = ptr_q + 10'd1;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    // The low pointer bits mark the last byte of a word since each load starts at 0.
                    if (ptr_q[1:0] == 2'd3) begin
                        wl_d = wl_inc;
                        if ({7'd0, wl_inc} == n_q) begin
                            state_d = ST_FINISH;
                        end
                    end
                end
            end
            ST_CHK: begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                if (accept) begin
                    state_d = (byte_in == csum_q) ? ST_DONE : ST_ERR;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    imem_byte_ram u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (ptr_q),
        .wdata (byte_in),
        .raddr (rd_addr[ADDR_W-1:0]),
        .rdata (rd_data)
    );

    logic unused_rd_hi;
    assign unused_rd_hi = ^rd_addr[31:ADDR_W];

    assign busy         = is_load_state(state_q);
    assign done         = (state_q == ST_DONE);
    assign err          = (state_q == ST_ERR);
    assign words_loaded = wl_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed-sequence bench for imem_loader with randomized payloads checked against
// a stream-level reference model of memory contents and load outcome.
module tb_imem_loader;
    import imem_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic        busy;
    logic        done;
    logic        err;
    logic [8:0]  words_loaded;
    state_e      dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  stream_q[$];
    logic [7:0]  exp_mem [MEM_BYTES];
    logic        exp_done;
    logic        exp_err;
    logic [8:0]  exp_words;
    bit          noise_start = 1'b0;

    always #5 clk = ~clk;

    imem_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .words_loaded (words_loaded),
        .dbg_state    (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: interpret the whole stream by the loader's rules.
    task automatic model_load();
        int n;
        logic [7:0] x;
        n = {24'd0, stream_q[0], stream_q[1]};
        x = 8'h00;
        exp_done = 1'b0;
        exp_err = 1'b0;
        exp_words = 9'd0;
        if (n > MAX_WORDS) begin
            exp_err = 1'b1;
        end else begin
            for (int i = 0; i < 4 * n; i++) begin
                exp_mem[i % MEM_BYTES] = stream_q[2 + i];
                x = x ^ stream_q[2 + i];
            end
            exp_words = 9'(n);
`ifdef IMEM_LOAD_CHECKSUM_EN
            if (stream_q[2 + 4 * n] == x) exp_done = 1'b1;
            else exp_err = 1'b1;
`else
            exp_done = 1'b1;
`endif
        end
    endtask

    task automatic append_csum();
`ifdef IMEM_LOAD_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
        for (int i = 2; i < stream_q.size(); i++) x = x ^ stream_q[i];
        stream_q.push_back(x);
`endif
    endtask

    task automatic make_stream(input int n);
        stream_q.delete();
        stream_q.push_back(8'(n >> 8));
        stream_q.push_back(8'(n));
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < 4 * n; i++) stream_q.push_back(8'($urandom));
            append_csum();
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: valid always, 1: random valid, 2: valid toggles every cycle
    task automatic send_stream(input int nbytes, input int mode);
        int idx;
        int cyc;
        bit ph;
        bit acc;
        idx = 0;
        cyc = 0;
        ph = 1'b0;
        while (idx < nbytes && cyc < 20000) begin
            @(negedge clk);
            case (mode)
                0: byte_valid = 1'b1;
                1: byte_valid = ($urandom_range(0, 3) != 0);
                default: begin byte_valid = ph; ph = ~ph; end
            endcase
            byte_in = byte_valid ? stream_q[idx] : 8'($urandom);
            start = noise_start ? 1'($urandom_range(0, 1)) : 1'b0;
            #1;
            acc = byte_valid && byte_ready;
            @(posedge clk);
            if (acc) idx++;
            cyc++;
        end
        @(negedge clk);
        byte_valid = 1'b0;
        start = 1'b0;
        check("stream_accepted", 32'(idx), 32'(nbytes));
    endtask

    task automatic check_outcome(input string tag);
        #1;
        check({tag, "_done"}, 32'(done), 32'(exp_done));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_ready"}, 32'(byte_ready), 32'd0);
        check({tag, "_words"}, 32'(words_loaded), 32'(exp_words));
        check({tag, "_state"}, 32'(dbg_state), exp_done ? 32'(ST_DONE) : 32'(ST_ERR));
    endtask

    task automatic check_rd(input string tag, input logic [31:0] addr);
        int a;
        a = int'(addr[9:0]);
        rd_addr = addr;
        #1;
        check(tag, rd_data, {exp_mem[a], exp_mem[(a + 1) % MEM_BYTES],
                             exp_mem[(a + 2) % MEM_BYTES], exp_mem[(a + 3) % MEM_BYTES]});
    endtask

    task automatic check_all_mem(input string tag);
        for (int a = 0; a < MEM_BYTES; a += 4) check_rd(tag, BASE_ADDR + 32'(a));
        check_rd({tag, "_wrap"}, 32'h0000_33FE);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        byte_in = 8'h00;
        byte_valid = 1'b0;
        rd_addr = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_words", 32'(words_loaded), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        reset = 1'b0;

        // Full 256-word image, exercises pointer wrap and fills every byte.
        make_stream(256);
        model_load();
        do_start();
        check("start_state", 32'(dbg_state), 32'(ST_HDR_HI));
        check("start_busy", 32'(busy), 32'd1);
        send_stream(stream_q.size(), 1);
        check_outcome("full");
        check_rd("full_last", 32'h0000_33FC);
        check_all_mem("full_mem");

        // Known single-word image.
        stream_q = '{8'h00, 8'h01, 8'h3C, 8'h08, 8'h00, 8'h10};
        append_csum();
        model_load();
        do_start();
        send_stream(stream_q.size(), 0);
        check_outcome("one");
        rd_addr = 32'h0000_3000;
        #1;
        check("one_word", rd_data, 32'h3C08_0010);

        // Two words with byte_valid toggling.
        make_stream(2);
        model_load();
        do_start();
        send_stream(stream_q.size(), 2);
        check_outcome("toggle");
        for (int a = 0; a < 12; a++) check_rd("toggle_mem", BASE_ADDR + 32'(a));

        // Oversized header: error, no writes, next start clears error.
        make_stream(257);
        model_load();
        do_start();
        send_stream(stream_q.size(), 0);
        check_outcome("big");
        check_all_mem("big_mem");
        do_start();
        check("clr_err", 32'(err), 32'd0);
        check("clr_done", 32'(done), 32'd0);
        check("clr_words", 32'(words_loaded), 32'd0);
        check("clr_state", 32'(dbg_state), 32'(ST_HDR_HI));
        make_stream(0);
        model_load();
        send_stream(stream_q.size(), 1);
        check_outcome("zero");

        // Reset after three payload bytes of word 0.
        make_stream(1);
        stream_q[5] = ~exp_mem[3];
        do_start();
        send_stream(5, 0);
        for (int i = 0; i < 3; i++) exp_mem[i] = stream_q[2 + i];
        reset = 1'b1;
        #1;
        check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_words", 32'(words_loaded), 32'd0);
        check_rd("midrst_mem0", 32'h0000_3000);
        check_rd("midrst_mem1", 32'h0000_3001);
        @(negedge clk);
        reset = 1'b0;
        check_rd("midrst_after", 32'h0000_3000);

`ifdef IMEM_LOAD_CHECKSUM_EN
        stream_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
        model_load();
        do_start();
        send_stream(stream_q.size(), 0);
        check_outcome("csum_ok");
        stream_q = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
        model_load();
        do_start();
        send_stream(stream_q.size(), 1);
        check_outcome("csum_bad");
        rd_addr = 32'h0000_3000;
        #1;
        check("csum_bad_mem", rd_data, 32'h1122_3344);
`endif

        // Random short loads with stray start pulses during the transfer.
        noise_start = 1'b1;
        for (int t = 0; t < 4; t++) begin
            make_stream($urandom_range(1, 16));
            model_load();
            do_start();
            send_stream(stream_q.size(), 1);
            check_outcome("rand");
            for (int k = 0; k < 8; k++) check_rd("rand_mem", BASE_ADDR + 32'($urandom_range(0, 80)));
        end
        noise_start = 1'b0;
        check_all_mem("final_mem");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
